sr_drive_ctrl: RTL and testbench
================================

Name: sr_drive_ctrl

Overview:
Synchronous driver for the set/reset inputs of an SR latch. It accepts level requests over a valid/ready handshake and emits timed, mutually exclusive set or reset pulses. Each pulse is followed by a mandatory idle gap. The block sits between control logic and any sr_latch instance, and guarantees the forbidden s=r=1 input never occurs.

Parameters:
PULSE_W, 2, cycles s or r is held high per request; legal range 1..255
GAP_W, 1, idle cycles with s=r=0 after each pulse before done; legal range 0..255
CNT_W, 8, width of the internal pulse/gap counter; must hold max(PULSE_W, GAP_W)

Ports:
clk  input  1  single clock, all state changes on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_level  input  1  requested latch state: 1 = set, 0 = reset
req_ready  output  1  block can accept a request this cycle
s  output  1  set drive to latch
r  output  1  reset drive to latch
done  output  1  one-cycle pulse when a request completes
busy  output  1  high in any state other than IDLE
level_q  output  1  last level driven; valid only when known_q=1
known_q  output  1  latch state is known (at least one pulse issued since reset)

Behaviour:
- Reset values, applied at the first rising edge with rst=1:
  - s=0, r=0, done=0, busy=0, level_q=0, known_q=0.
  - req_ready=1 once rst is deasserted.
  - FSM=IDLE, counter=0.
- FSM states: IDLE, PULSE, GAP, FIN.
- IDLE:
  - req_ready=1.
  - A request is accepted on a cycle where req_valid=1.
  - Skip case, known_q=1 and req_level==level_q: no pulse. done=1 on the next cycle, FSM stays IDLE, and back-to-back accepts are allowed.
  - Otherwise: latch req_level, load counter=PULSE_W-1, go to PULSE.
- PULSE:
  - s=lvl and r=~lvl, registered outputs.
  - The first s/r high cycle is the cycle after acceptance.
  - Counter decrements each cycle. At 0: set level_q=lvl, known_q=1.
  - On exit, go to GAP with counter=GAP_W-1 if GAP_W>0, else go to FIN.
- GAP:
  - s=r=0; counter decrements each cycle.
  - At 0, go to FIN.
- FIN:
  - done=1 for exactly one cycle, then IDLE.
  - req_ready returns to 1 in the IDLE cycle after FIN.
- Latency from accept to done: 1+PULSE_W+GAP_W cycles (PULSE_W=2, GAP_W=1 gives 4).
- req_ready=0 and busy=1 in PULSE, GAP and FIN. req_valid is ignored in these states and requests are not queued.
- Invariant: s&r is never 1 on any cycle, including the reset cycle.
- Reset mid-operation:
  - s and r drop at the reset edge, and any pending done is lost.
  - known_q=0, so the next request always pulses, even if it repeats the previous level.
- Counter arithmetic is unsigned CNT_W bits and never wraps. Decrement occurs only while the counter is greater than 0.

Optional Feature:
- Macro name: SR_DRIVE_FEEDBACK_CHECK_EN.
- Defined:
  - Adds input q_fb (1 bit) and output fb_err (1 bit, sticky).
  - In FIN, q_fb is compared against lvl. On mismatch, fb_err is set to 1.
  - fb_err is cleared only by rst. done still pulses when fb_err is set.
- Not defined:
  - No q_fb or fb_err ports and no compare logic.
  - All other behaviour is identical.

Decomposition:
- Package sr_drive_pkg holds:
  - FSM state encodings: IDLE=2'd0, PULSE=2'd1, GAP=2'd2, FIN=2'd3.
  - Default PULSE_W and GAP_W constants.
- One sub-module, sr_pulse_timer: loadable down-counter.
  - Ports: clk, rst, load, load_val[CNT_W], zero flag.
  - Instantiated once and shared between the PULSE and GAP phases.

Test Plan:
- Reset then req_valid=1, req_level=1 at cycle 0 (PULSE_W=2, GAP_W=1) -> s=1 on cycles 1-2, s=r=0 on cycle 3, done=1 on cycle 4, level_q=1, known_q=1, req_ready=1 on cycle 5.
- After a set, request level=1 again -> no s/r activity, done=1 on the next cycle, busy stays 0.
- After a set, request level=0 -> r=1 for 2 cycles, s stays 0 throughout, level_q=0 after done.
- Hold req_valid=1 with alternating levels for 20 cycles -> accepts only while req_ready=1, s&r never 1, each done spaced exactly 4 cycles after its accept.
- Assert rst during the second PULSE cycle -> s=0 at that edge, no done, known_q=0; a following request at level 1 (same as the interrupted one) still pulses s.
- With SR_DRIVE_FEEDBACK_CHECK_EN defined and q_fb tied to 0, request level=1 -> fb_err=1 from the FIN cycle onward, done still asserted, fb_err remains 1 until rst.

Source files
------------

// File: rtl/sr_drive_pkg.sv
// Shared types and defaults for the SR latch drive controller.
package sr_drive_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } drive_state_e;

  localparam int unsigned PULSE_W_DEF = 32'd2;
  localparam int unsigned GAP_W_DEF   = 32'd1;
  localparam int unsigned CNT_W_DEF   = 32'd8;

endpackage

// File: rtl/sr_drive_ctrl_if.sv
// Level-request handshake between control logic and the SR drive controller.
interface sr_drive_ctrl_if;
  logic req_valid;
  logic req_level;
  logic req_ready;

  modport master (output req_valid, output req_level, input req_ready);
  modport slave  (input req_valid, input req_level, output req_ready);
endinterface

// File: rtl/sr_drive_ctrl_chk.sv
// Safety properties of the SR drive outputs.
module sr_drive_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic s,
  input logic r,
  input logic busy,
  input logic req_ready
);

  a_no_forbidden: assert property (@(posedge clk) !(s && r));
  a_ready_busy:   assert property (@(posedge clk) disable iff (rst) busy == !req_ready);

endmodule

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter that stops at zero; shared by pulse and gap phases.
module sr_pulse_timer #(
  parameter int unsigned CNT_W = 32'd8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // Counter register: load has priority, otherwise saturating decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != CNT_ZERO) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/sr_drive_ctrl.sv
// SR latch set/reset pulse driver with mandatory idle gap.
// Optional feedback compare enabled by SR_DRIVE_FEEDBACK_CHECK_EN.
module sr_drive_ctrl
  import sr_drive_pkg::*;
#(
  parameter int unsigned PULSE_W = PULSE_W_DEF,
  parameter int unsigned GAP_W   = GAP_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  sr_drive_ctrl_if.slave  req,
  output logic            s,
  output logic            r,
  output logic            done,
  output logic            busy,
  output logic            level_q,
  output logic            known_q
`ifdef SR_DRIVE_FEEDBACK_CHECK_EN
  ,
  input  logic            q_fb,
  output logic            fb_err
`endif
);

  localparam bit               HAS_GAP  = (GAP_W > 32'd0);
  localparam int unsigned      GAP_LD_I = HAS_GAP ? (GAP_W - 32'd1) : 32'd0;
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 32'd1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_LD_I);

  drive_state_e     state_r;
  logic             lvl_r;
  logic             s_r;
  logic             r_r;
  logic             done_r;
  logic             busy_r;
  logic             ready_r;
  logic             level_r;
  logic             known_r;
  logic             skip_s;
  logic             load_s;
  logic [CNT_W-1:0] load_val_s;
  logic             zero_s;

  // A repeat of the known latch level needs no pulse.
  assign skip_s = known_r && (req.req_level == level_r);

  // Timer load control for entering PULSE and GAP.
  always_comb begin
    load_s     = 1'b0;
    load_val_s = PULSE_LD;
    case (state_r)
      IDLE: begin
        if (req.req_valid && !skip_s) begin
          load_s     = 1'b1;
          load_val_s = PULSE_LD;
        end else begin
          load_s     = 1'b0;
        end
      end
      PULSE: begin
        if (zero_s && HAS_GAP) begin
          load_s     = 1'b1;
          load_val_s = GAP_LD;
        end else begin
          load_s     = 1'b0;
        end
      end
      default: begin
        load_s     = 1'b0;
        load_val_s = PULSE_LD;
      end
    endcase
  end

  sr_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (load_val_s),
    .zero     (zero_s)
  );

  // Control FSM with registered drive and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      lvl_r   <= 1'b0;
      s_r     <= 1'b0;
      r_r     <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
      level_r <= 1'b0;
      known_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req.req_valid && skip_s) begin
            done_r <= 1'b1;
          end else if (req.req_valid) begin
            state_r <= PULSE;
            lvl_r   <= req.req_level;
            s_r     <= req.req_level;
            r_r     <= ~req.req_level;
            busy_r  <= 1'b1;
            ready_r <= 1'b0;
            done_r  <= 1'b0;
          end else begin
            done_r  <= 1'b0;
          end
        end
        PULSE: begin
          if (zero_s) begin
            level_r <= lvl_r;
            known_r <= 1'b1;
            s_r     <= 1'b0;
            r_r     <= 1'b0;
            if (HAS_GAP) begin
              state_r <= GAP;
            end else begin
              state_r <= FIN;
              done_r  <= 1'b1;
            end
          end
        end
        GAP: begin
          if (zero_s) begin
            state_r <= FIN;
            done_r  <= 1'b1;
          end
        end
        FIN: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          s_r     <= 1'b0;
          r_r     <= 1'b0;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

`ifdef SR_DRIVE_FEEDBACK_CHECK_EN
  logic fb_err_r;
  logic fin_next_s;

  // Compare on entry to FIN so the flag is already visible during FIN.
  assign fin_next_s = zero_s && ((state_r == GAP) || ((state_r == PULSE) && !HAS_GAP));

  // Sticky feedback mismatch flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_err_r <= 1'b0;
    end else if ((fin_next_s || (state_r == FIN)) && (q_fb != lvl_r)) begin
      fb_err_r <= 1'b1;
    end else begin
      fb_err_r <= fb_err_r;
    end
  end

  assign fb_err = fb_err_r;
`endif

  assign s             = s_r;
  assign r             = r_r;
  assign done          = done_r;
  assign busy          = busy_r;
  assign level_q       = level_r;
  assign known_q       = known_r;
  assign req.req_ready = ready_r;

  sr_drive_ctrl_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .s         (s_r),
    .r         (r_r),
    .busy      (busy_r),
    .req_ready (ready_r)
  );

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed plus random bench for sr_drive_ctrl against a cycle-schedule reference model.
module tb_sr_drive_ctrl;

  localparam int P = 2;
  localparam int G = 1;

  logic clk = 1'b0;
  logic rst;
  logic s, r, done, busy, level_q, known_q;
`ifdef SR_DRIVE_FEEDBACK_CHECK_EN
  logic q_fb = 1'b0;
  logic fb_err;
`endif

  sr_drive_ctrl_if bus();

  sr_drive_ctrl #(.PULSE_W(P), .GAP_W(G), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (bus),
    .s       (s),
    .r       (r),
    .done    (done),
    .busy    (busy),
    .level_q (level_q),
    .known_q (known_q)
`ifdef SR_DRIVE_FEEDBACK_CHECK_EN
    ,
    .q_fb    (q_fb),
    .fb_err  (fb_err)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: an operation accepted in cycle oa drives the latch in
  // cycles oa+1..oa+P, is busy through oa+1+P+G and signals done at its end.
  bit mk     = 1'b0;
  bit ml     = 1'b0;
  bit op     = 1'b0;
  int oa     = 0;
  bit olvl   = 1'b0;
  int sk     = -100;
  bit mready = 1'b1;

  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    bit in_op;
    bit drive;
    bit ed;
    if (op && cyc == oa + P + 1) begin
      mk = 1'b1;
      ml = olvl;
    end
    if (op && cyc > oa + 1 + P + G) op = 1'b0;
    in_op = op && (cyc >= oa + 1) && (cyc <= oa + 1 + P + G);
    drive = in_op && (cyc <= oa + P);
    ed    = (op && cyc == oa + 1 + P + G) || (sk == cyc - 1);
    chk("s", s, drive && olvl);
    chk("r", r, drive && !olvl);
    chk("s_and_r", s & r, 1'b0);
    chk("done", done, ed);
    chk("busy", busy, in_op);
    chk("req_ready", bus.req_ready, !in_op);
    chk("known_q", known_q, mk);
    chk("level_q", level_q, ml);
    mready = !in_op;
  endtask

  task automatic step(bit v, bit l);
    bus.req_valid = v;
    bus.req_level = l;
    @(posedge clk);
    if (rst) begin
      op = 1'b0; mk = 1'b0; ml = 1'b0; sk = -100;
    end else if (mready && v) begin
      if (mk && (l == ml)) begin
        sk = cyc;
      end else begin
        op = 1'b1; oa = cyc; olvl = l;
      end
    end
    cyc++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_level = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(1);

    // First set: s on two cycles, gap, done, ready again.
    step(1'b1, 1'b1);
    idle(6);
    // Repeat of the known level: done only, no drive.
    step(1'b1, 1'b1);
    idle(3);
    // Reset level after a set.
    step(1'b1, 1'b0);
    idle(6);
    // Held valid with alternating levels.
    for (int i = 0; i < 20; i++) step(1'b1, i[0]);
    idle(6);

    // Reset during the second pulse cycle, then the same level must pulse again.
    step(1'b1, 1'b0);
    idle(6);
    step(1'b1, 1'b1);
    idle(1);
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_mid_known", known_q, 1'b0);
    step(1'b1, 1'b1);
    chk("rst_repulse_s", s, 1'b1);
    idle(6);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rst = 1'b0;
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
